// File: rtl/data_memory_arbiter_if.sv
// Bus bundle between the two data-memory requesters, the arbiter and the memory.
// The slave modport is the arbiter's view. The master modport is the environment's view:
// the requesters plus the memory that supplies mem_rdata.
interface data_memory_arbiter_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  a_req;
  logic                  a_we;
  logic [DATA_WIDTH-1:0] a_addr;
  logic [DATA_WIDTH-1:0] a_wdata;
  logic                  a_ack;
  logic [DATA_WIDTH-1:0] a_rdata;
  logic                  a_err;

  logic                  b_req;
  logic                  b_we;
  logic [DATA_WIDTH-1:0] b_addr;
  logic [DATA_WIDTH-1:0] b_wdata;
  logic                  b_ack;
  logic [DATA_WIDTH-1:0] b_rdata;
  logic                  b_err;

  logic [DATA_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_write;
  logic                  mem_read;
  logic [DATA_WIDTH-1:0] mem_rdata;

  logic                  busy;

  modport slave (
    input  a_req, a_we, a_addr, a_wdata,
    output a_ack, a_rdata, a_err,
    input  b_req, b_we, b_addr, b_wdata,
    output b_ack, b_rdata, b_err,
    output mem_addr, mem_wdata, mem_write, mem_read,
    input  mem_rdata,
    output busy
  );

  modport master (
    output a_req, a_we, a_addr, a_wdata,
    input  a_ack, a_rdata, a_err,
    output b_req, b_we, b_addr, b_wdata,
    input  b_ack, b_rdata, b_err,
    input  mem_addr, mem_wdata, mem_write, mem_read,
    output mem_rdata,
    input  busy
  );
endinterface

// File: rtl/data_memory_arbiter.sv
// Round-robin arbiter sharing the single-port data memory between port A (CPU MEM stage)
// and port B (debug/DMA loader). One access in flight; each access takes IDLE -> ACCESS -> RESP.
//
//   state  | meaning
//   IDLE   | waiting; a request seen here is latched together with its range/alignment result
//   ACCESS | memory driven from the latched request; a write commits at the closing edge
//   RESP   | winner sees ack with registered rdata/err for exactly one cycle
//
// The memory strobes come straight from registers, so asserting reset mid-ACCESS pulls
// mem_write low asynchronously and the pending write never lands.
module data_memory_arbiter #(
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    MEMORY_DEPTH = 256,
  parameter logic [DATA_WIDTH-1:0] BASE_ADDR    = 32'h1001_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  data_memory_arbiter_if.slave  bus
);

  localparam logic [DATA_WIDTH-1:0] SPAN_BYTES = DATA_WIDTH'(4 * MEMORY_DEPTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t                state;
  logic                  lastGrantB;
  logic                  grantB;
  logic                  okReg;
  logic [DATA_WIDTH-1:0] memAddrQ;
  logic [DATA_WIDTH-1:0] memWdataQ;
  logic                  memWriteQ;
  logic                  memReadQ;
  logic                  aAckQ;
  logic                  aErrQ;
  logic [DATA_WIDTH-1:0] aRdataQ;
  logic                  bAckQ;
  logic                  bErrQ;
  logic [DATA_WIDTH-1:0] bRdataQ;

  logic                  pickB;
  logic                  selWe;
  logic                  selOk;
  logic [DATA_WIDTH-1:0] selAddr;
  logic [DATA_WIDTH-1:0] selWdata;
  logic [DATA_WIDTH-1:0] selOffset;
  logic [DATA_WIDTH-1:0] respData;

  // Pick the IDLE winner (B only if alone or A was served last) and qualify its address.
  always_comb begin
    pickB     = bus.b_req & (~bus.a_req | ~lastGrantB);
    selWe     = pickB ? bus.b_we    : bus.a_we;
    selAddr   = pickB ? bus.b_addr  : bus.a_addr;
    selWdata  = pickB ? bus.b_wdata : bus.a_wdata;
    selOffset = selAddr - BASE_ADDR;
    selOk     = (selAddr[1:0] == 2'b00) && (selAddr >= BASE_ADDR) && (selOffset < SPAN_BYTES);
    respData  = memReadQ ? bus.mem_rdata : '0;
  end

  // Sequencer: latches the request, drives the memory for one cycle, then returns the response.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      lastGrantB <= 1'b1;
      grantB     <= 1'b0;
      okReg      <= 1'b0;
      memAddrQ   <= '0;
      memWdataQ  <= '0;
      memWriteQ  <= 1'b0;
      memReadQ   <= 1'b0;
      aAckQ      <= 1'b0;
      aErrQ      <= 1'b0;
      aRdataQ    <= '0;
      bAckQ      <= 1'b0;
      bErrQ      <= 1'b0;
      bRdataQ    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.a_req || bus.b_req) begin
            grantB    <= pickB;
            okReg     <= selOk;
            memAddrQ  <= selAddr;
            memWdataQ <= selWdata;
            memWriteQ <= selWe & selOk;
            memReadQ  <= ~selWe & selOk;
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          memAddrQ   <= '0;
          memWdataQ  <= '0;
          memWriteQ  <= 1'b0;
          memReadQ   <= 1'b0;
          lastGrantB <= grantB;
          if (grantB) begin
            bAckQ   <= 1'b1;
            bErrQ   <= ~okReg;
            bRdataQ <= respData;
          end else begin
            aAckQ   <= 1'b1;
            aErrQ   <= ~okReg;
            aRdataQ <= respData;
          end
          state <= RESP;
        end
        RESP: begin
          aAckQ   <= 1'b0;
          aErrQ   <= 1'b0;
          aRdataQ <= '0;
          bAckQ   <= 1'b0;
          bErrQ   <= 1'b0;
          bRdataQ <= '0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.a_ack     = aAckQ;
  assign bus.a_err     = aErrQ;
  assign bus.a_rdata   = aRdataQ;
  assign bus.b_ack     = bAckQ;
  assign bus.b_err     = bErrQ;
  assign bus.b_rdata   = bRdataQ;
  assign bus.mem_addr  = memAddrQ;
  assign bus.mem_wdata = memWdataQ;
  assign bus.mem_write = memWriteQ;
  assign bus.mem_read  = memReadQ;
  assign bus.busy      = (state != IDLE);

endmodule
